// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_frame_pkg;

  // Controller states; S_HUNT is the only idle state.
  typedef enum logic [2:0] {
    S_HUNT  = 3'd0,
    S_LEN   = 3'd1,
    S_PAY   = 3'd2,
    S_CSUM  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  // Abort causes reported on err_code.
  typedef enum logic [2:0] {
    ERR_NONE = 3'd0,
    ERR_LEN  = 3'd1,
    ERR_CSUM = 3'd2,
    ERR_FERR = 3'd3,
    ERR_OVR  = 3'd4,
    ERR_TMO  = 3'd5
  } err_t;

  // Default frame start marker.
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload holding buffer: DEPTH x 8 register file, one write port, one async read port.
// Latency: write lands on the next clk edge; read is combinational.
// Backpressure: none; out-of-range writes are ignored and out-of-range reads return 0.
// Ports:
//   clk      system clock
//   wr_en    write strobe
//   wr_addr  write byte index
//   wr_data  write byte
//   rd_addr  read byte index
//   rd_data  read byte (combinational)
module uart_frame_buf #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       wr_en,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [7:0] rd_addr,
  output logic [7:0] rd_data
);

  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0] DEPTH_B = 8'(DEPTH);

  logic [7:0] mem [DEPTH];

  // Storage is deliberately not reset: stale bytes are never presented because
  // the drain only reads indices below the length of a verified frame.
  always_ff @(posedge clk) begin
    if (wr_en && (wr_addr < DEPTH_B)) begin
      mem[wr_addr[AW-1:0]] <= wr_data;
    end
  end

  // The drain prefetches rd+1 on its final beat, which may equal DEPTH.
  assign rd_data = (rd_addr < DEPTH_B) ? mem[rd_addr[AW-1:0]] : 8'h00;

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Frame controller behind uart_rx: hunts SYNC, parses LEN/PAYLOAD/CSUM, releases payload only after checksum passes.
// Latency: frame_ok 1 cycle after the CSUM byte strobe; first out_valid 1 cycle after frame_ok.
// Backpressure: valid/ready on the output; out_* held while out_ready=0; rx side cannot be stalled (bytes during drain abort with ERR_OVR).
// Optional feature: define UART_FRAME_TIMEOUT_EN to build the inter-byte timeout (ERR_TMO).
// Ports:
//   clk, rst                 system clock, synchronous active-high reset
//   rx_data/rx_valid/rx_ferr byte, strobe and framing error from uart_rx
//   out_data/out_valid/out_ready/out_last  verified payload stream
//   frame_ok, frame_err      1-cycle pulses for accepted / aborted frames
//   err_code                 cause of last abort, held until the next abort or reset
//   busy                     high whenever not hunting for SYNC
module uart_rx_frame_ctrl
  import uart_frame_pkg::*;
#(
  parameter int         MAX_LEN        = 16,
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_ferr,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [2:0] err_code,
  output logic       busy
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_t     state;
  logic [7:0] len;
  logic [7:0] csum;
  logic [7:0] idx;
  logic [7:0] rd;
  logic [7:0] idx_nxt;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic       buf_we;
  logic       tmo_hit;

  assign idx_nxt = idx + 8'd1;
  // While a beat is on the bus, look ahead to the next one so it can be
  // registered on the same edge the current beat completes.
  assign rd_addr = out_valid ? (rd + 8'd1) : rd;
  assign buf_we  = (state == S_PAY) && rx_valid && !rx_ferr;
  assign busy    = (state != S_HUNT);

  uart_frame_buf #(
    .DEPTH (MAX_LEN)
  ) u_pay_buf (
    .clk     (clk),
    .wr_en   (buf_we),
    .wr_addr (idx),
    .wr_data (rx_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int             TW       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmo_cnt;
  logic          in_frame;

  assign in_frame = (state == S_LEN) || (state == S_PAY) || (state == S_CSUM);
  assign tmo_hit  = in_frame && (tmo_cnt == TMO_LAST);

  // Counts idle cycles since the last byte while a frame is in progress.
  always_ff @(posedge clk) begin
    if (rst || rx_valid || !in_frame) begin
      tmo_cnt <= '0;
    end else if (!tmo_hit) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^TIMEOUT_CYCLES;
  assign tmo_hit        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_HUNT;
      len       <= 8'h00;
      csum      <= 8'h00;
      idx       <= 8'h00;
      rd        <= 8'h00;
      out_data  <= 8'h00;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;

      case (state)
        S_HUNT: begin
          if (rx_valid && !rx_ferr && (rx_data == SYNC_BYTE)) begin
            state <= S_LEN;
          end
        end

        S_LEN, S_PAY, S_CSUM: begin
          if (rx_valid) begin
            // A framing error outranks every content check.
            if (rx_ferr) begin
              frame_err <= 1'b1;
              err_code  <= ERR_FERR;
              state     <= S_HUNT;
            end else begin
              case (state)
                S_LEN: begin
                  len  <= rx_data;
                  csum <= rx_data;
                  idx  <= 8'h00;
                  if (rx_data == 8'h00) begin
                    state <= S_CSUM;
                  end else if (rx_data > MAX_LEN_B) begin
                    frame_err <= 1'b1;
                    err_code  <= ERR_LEN;
                    state     <= S_HUNT;
                  end else begin
                    state <= S_PAY;
                  end
                end
                S_PAY: begin
                  csum <= csum ^ rx_data;
                  idx  <= idx_nxt;
                  if (idx_nxt == len) begin
                    state <= S_CSUM;
                  end
                end
                S_CSUM: begin
                  if (rx_data == csum) begin
                    frame_ok <= 1'b1;
                    rd       <= 8'h00;
                    state    <= (len != 8'h00) ? S_DRAIN : S_HUNT;
                  end else begin
                    frame_err <= 1'b1;
                    err_code  <= ERR_CSUM;
                    state     <= S_HUNT;
                  end
                end
                default: state <= S_HUNT;
              endcase
            end
          end else if (tmo_hit) begin
            frame_err <= 1'b1;
            err_code  <= ERR_TMO;
            state     <= S_HUNT;
          end
        end

        S_DRAIN: begin
          // The rx side cannot be stalled: a byte arriving now is lost and
          // reported, but the verified payload still drains intact.
          if (rx_valid) begin
            frame_err <= 1'b1;
            err_code  <= ERR_OVR;
          end

          if (!out_valid) begin
            out_valid <= 1'b1;
            out_data  <= rd_data;
            out_last  <= (rd == (len - 8'd1));
          end else if (out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              state     <= S_HUNT;
            end else begin
              rd       <= rd + 8'd1;
              out_data <= rd_data;
              out_last <= ((rd + 8'd1) == (len - 8'd1));
            end
          end
        end

        default: state <= S_HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Self-checking bench for uart_rx_frame_ctrl with a scoreboard of expected beats and frame events.
// Latency: n/a.
// Backpressure: out_ready is driven by the directed tests.
module tb_uart_rx_frame_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ferr;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       frame_ok;
  logic       frame_err;
  logic [2:0] err_code;
  logic       busy;

  uart_rx_frame_ctrl #(
    .MAX_LEN        (16),
    .SYNC_BYTE      (8'hA5),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ferr   (rx_ferr),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .err_code  (err_code),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       l;
  } beat_t;

  typedef struct {
    logic       is_err;
    logic [2:0] code;
  } ev_t;

  beat_t      beat_q[$];
  ev_t        ev_q[$];
  logic [7:0] seq[$];
  int         ferr_pos;
  int         checks;
  int         failures;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push_beat(input logic [7:0] d, input logic l);
    beat_t b;
    b.d = d;
    b.l = l;
    beat_q.push_back(b);
  endtask

  task automatic push_ev(input logic is_err, input logic [2:0] code);
    ev_t e;
    e.is_err = is_err;
    e.code   = code;
    ev_q.push_back(e);
  endtask

  // Sends every byte of seq as a 1-cycle strobe with an idle cycle between;
  // the byte at position ferr_pos carries a framing error.
  task automatic send_seq();
    foreach (seq[i]) begin
      @(posedge clk); #1;
      rx_valid = 1'b1;
      rx_data  = seq[i];
      rx_ferr  = (i == ferr_pos);
      @(posedge clk); #1;
      rx_valid = 1'b0;
      rx_ferr  = 1'b0;
    end
    ferr_pos = -1;
  endtask

  task automatic wait_idle(input string name, input int max_cycles);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max_cycles && !done; i++) begin
      @(negedge clk);
      if (beat_q.size() == 0 && ev_q.size() == 0 && !busy) done = 1'b1;
    end
    check({name, "_idle"}, {31'd0, done}, 32'd1);
  endtask

  task automatic wait_valid(input string name, input int max_cycles);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max_cycles && !done; i++) begin
      @(negedge clk);
      if (out_valid) done = 1'b1;
    end
    check({name, "_valid_seen"}, {31'd0, done}, 32'd1);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Monitor: compares every completed beat and every frame event against the
  // scoreboard queues, and checks that a stalled beat stays put.
  logic       stall_prev;
  logic [7:0] held_d;
  logic       held_l;

  initial begin
    beat_t b;
    ev_t   e;
    stall_prev = 1'b0;
    held_d     = 8'h00;
    held_l     = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          checks++;
          if (!out_valid || out_data !== held_d || out_last !== held_l) begin
            failures++;
            $display("FAIL hold_stable actual=v%0b d%0h l%0b expected=v1 d%0h l%0b",
                     out_valid, out_data, out_last, held_d, held_l);
          end
        end
        stall_prev = out_valid && !out_ready;
        held_d     = out_data;
        held_l     = out_last;

        if (out_valid && out_ready) begin
          checks++;
          if (beat_q.size() == 0) begin
            failures++;
            $display("FAIL beat_unexpected actual=d%0h l%0b expected=none", out_data, out_last);
          end else begin
            b = beat_q.pop_front();
            if (out_data !== b.d || out_last !== b.l) begin
              failures++;
              $display("FAIL beat actual=d%0h l%0b expected=d%0h l%0b", out_data, out_last, b.d, b.l);
            end
          end
        end

        if (frame_ok) begin
          checks++;
          if (ev_q.size() == 0) begin
            failures++;
            $display("FAIL frame_ok_unexpected actual=ok expected=none");
          end else begin
            e = ev_q.pop_front();
            if (e.is_err) begin
              failures++;
              $display("FAIL frame_ok actual=ok expected=err code%0d", e.code);
            end
          end
        end

        if (frame_err) begin
          checks++;
          if (ev_q.size() == 0) begin
            failures++;
            $display("FAIL frame_err_unexpected actual=err code%0d expected=none", err_code);
          end else begin
            e = ev_q.pop_front();
            if (!e.is_err || err_code !== e.code) begin
              failures++;
              $display("FAIL frame_err actual=err code%0d expected=is_err%0b code%0d",
                       err_code, e.is_err, e.code);
            end
          end
        end
      end
    end
  end

  initial begin
    checks    = 0;
    failures  = 0;
    ferr_pos  = -1;
    rst       = 1'b1;
    rx_data   = 8'h00;
    rx_valid  = 1'b0;
    rx_ferr   = 1'b0;
    out_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'h00);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err_code", {29'd0, err_code}, 32'd0);
    check("rst_pulses", {30'd0, frame_ok, frame_err}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: basic three-byte frame, checksum 03^11^22^33 = 03.
    push_ev(1'b0, 3'd0);
    push_beat(8'h11, 1'b0);
    push_beat(8'h22, 1'b0);
    push_beat(8'h33, 1'b1);
    seq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    send_seq();
    wait_idle("t1", 50);
    check("t1_err_code", {29'd0, err_code}, 32'd0);

    // 2: empty frame, no output beats.
    push_ev(1'b0, 3'd0);
    seq = '{8'hA5, 8'h00, 8'h00};
    send_seq();
    wait_idle("t2", 20);
    check("t2_busy", {31'd0, busy}, 32'd0);

    // 3: bad checksum, then the same frame with the correct one (01^5A = 5B).
    push_ev(1'b1, 3'd2);
    seq = '{8'hA5, 8'h01, 8'h5A, 8'h00};
    send_seq();
    wait_idle("t3a", 20);
    check("t3a_err_code", {29'd0, err_code}, 32'd2);
    push_ev(1'b0, 3'd0);
    push_beat(8'h5A, 1'b1);
    seq = '{8'hA5, 8'h01, 8'h5A, 8'h5B};
    send_seq();
    wait_idle("t3b", 20);

    // 4: leading junk is silent; length 17 exceeds the buffer.
    push_ev(1'b1, 3'd1);
    seq = '{8'h00, 8'hFF, 8'hA5, 8'h11};
    send_seq();
    wait_idle("t4", 20);
    check("t4_err_code", {29'd0, err_code}, 32'd1);

    // 5a: framing error on payload byte 22; trailing 33 03 are hunted over.
    push_ev(1'b1, 3'd3);
    seq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    ferr_pos = 3;
    send_seq();
    wait_idle("t5a", 20);
    check("t5a_err_code", {29'd0, err_code}, 32'd3);

    // 5b: downstream stall of 5 cycles while beat 22 is presented.
    out_ready = 1'b0;
    push_ev(1'b0, 3'd0);
    push_beat(8'h11, 1'b0);
    push_beat(8'h22, 1'b0);
    push_beat(8'h33, 1'b1);
    seq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    send_seq();
    wait_valid("t5b", 20);
    check("t5b_first_data", {24'd0, out_data}, 32'h11);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("t5b_stalled_data", {24'd0, out_data}, 32'h22);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_idle("t5b", 20);

    // Sync byte inside a frame is payload: checksum 02^A5^01 = A6.
    push_ev(1'b0, 3'd0);
    push_beat(8'hA5, 1'b0);
    push_beat(8'h01, 1'b1);
    seq = '{8'hA5, 8'h02, 8'hA5, 8'h01, 8'hA6};
    send_seq();
    wait_idle("sync_data", 20);

    // Longest legal frame: 16 bytes 10..1F, XOR of payload is 00 so CSUM = 10.
    push_ev(1'b0, 3'd0);
    seq = '{8'hA5, 8'h10};
    for (int i = 0; i < 16; i++) begin
      seq.push_back(8'h10 + 8'(i));
      push_beat(8'h10 + 8'(i), (i == 15));
    end
    seq.push_back(8'h10);
    send_seq();
    wait_idle("max_len", 80);

    // Byte arriving during drain: ERR_OVR reported, payload still drains.
    out_ready = 1'b0;
    push_ev(1'b0, 3'd0);
    push_ev(1'b1, 3'd4);
    push_beat(8'h11, 1'b0);
    push_beat(8'h22, 1'b0);
    push_beat(8'h33, 1'b1);
    seq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03, 8'h77};
    send_seq();
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_idle("ovr", 30);
    check("ovr_err_code", {29'd0, err_code}, 32'd4);

    // Reset mid-drain: beat abandoned, everything back to reset values.
    out_ready = 1'b0;
    push_ev(1'b0, 3'd0);
    seq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    send_seq();
    wait_valid("rst_drain", 20);
    pulse_reset();
    @(negedge clk);
    check("rst_drain_valid", {31'd0, out_valid}, 32'd0);
    check("rst_drain_busy", {31'd0, busy}, 32'd0);
    check("rst_drain_err_code", {29'd0, err_code}, 32'd0);
    out_ready = 1'b1;
    repeat (5) @(negedge clk);

    // Stalled frame: timeout abort when built in, otherwise waits forever.
    seq = '{8'hA5, 8'h02, 8'h11};
`ifdef UART_FRAME_TIMEOUT_EN
    push_ev(1'b1, 3'd5);
    send_seq();
    wait_idle("tmo", 300);
    check("tmo_err_code", {29'd0, err_code}, 32'd5);
`else
    send_seq();
    repeat (110) @(negedge clk);
    check("no_tmo_busy", {31'd0, busy}, 32'd1);
    check("no_tmo_err_code", {29'd0, err_code}, 32'd0);
    pulse_reset();
`endif

    repeat (3) @(negedge clk);
    check("end_beat_q_empty", beat_q.size(), 32'd0);
    check("end_ev_q_empty", ev_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
